bin2bcd_n: RTL

BIN2BCD_N -- requirements
Module: bin2bcd_n

---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bin2bcd_n_adj.sv | 12 +
 rtl/bin2bcd_n.sv | 112 +++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types for the iterative binary-to-BCD converter: FSM state encoding
// and the 4-bit BCD digit type used by the top and the digit adjuster.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADJ_THRESHOLD = 4'd4;
    localparam bcd_digit_t ADJ_OFFSET    = 4'd3;

endpackage

// File: rtl/bin2bcd_n_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit exceeds 4
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din > ADJ_THRESHOLD) ? din + ADJ_OFFSET : din;

endmodule

// File: rtl/bin2bcd_n.sv
// Sequential shift-and-add-3 binary-to-BCD converter with optional two's
// complement input, sticky overflow and a leading-zero blanking mask.
module bin2bcd_n
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  sgn_mode,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    bcd_digit_t         digits  [DIGITS];
    bcd_digit_t         adj     [DIGITS];
    bcd_digit_t         shifted [DIGITS];
    logic [BIN_W-1:0]   mag;
    logic               is_neg;
    logic               all_zero;

    // Negating the most negative value wraps to itself, which read as unsigned is 2^(BIN_W-1).
    always_comb begin
        is_neg = sgn_mode & bin[BIN_W-1];
        mag    = is_neg ? -bin : bin;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .din  (digits[g]),
            .dout (adj[g])
        );
        if (g == 0) begin : g_lsd
            assign shifted[g] = {adj[g][2:0], shreg[BIN_W-1]};
        end else begin : g_upper
            assign shifted[g] = {adj[g][2:0], adj[g-1][3]};
        end
        assign bcd[4*g +: 4] = digits[g];
    end

    always_comb begin
        all_zero = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (digits[i] == 4'd0);
            blank[i] = all_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            digits    <= '{default: '0};
            neg       <= 1'b0;
            ovf       <= 1'b0;
            ready     <= 1'b1;
            done_tick <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_OP;
                        ready  <= 1'b0;
                        shreg  <= mag;
                        neg    <= is_neg;
                        ovf    <= 1'b0;
                        cnt    <= CNT_W'(BIN_W);
                        digits <= '{default: '0};
                    end
                end
                ST_OP: begin
                    digits <= shifted;
                    shreg  <= {shreg[BIN_W-2:0], 1'b0};
                    cnt    <= cnt - 1'b1;
                    // A set bit 3 in the adjusted top digit is shifted out of the result.
                    if (adj[DIGITS-1][3]) begin
                        ovf <= 1'b1;
                    end
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_DONE;
                        done_tick <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
